// File: rtl/axis_data_chk_pkg.sv
// Shared types and constants for the AXI-Stream pattern checker and its
// backpressure LFSR.
package axis_data_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Fibonacci taps 16,14,13,11 for a right-shifting register (bits 0,2,3,5)
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/bp_lfsr.sv
// 16-bit Fibonacci LFSR used to throttle a stream handshake; load wins over
// advance, and reset behaves like a load of the seed.
module bp_lfsr
  import axis_data_chk_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= seed;
    end else if (advance) begin
      state <= {^(state & LFSR_TAPS), state[15:1]};
    end
  end

endmodule

// File: rtl/axis_data_chk.sv
// AXI-Stream sink that checks an incrementing data pattern and tlast placement
// over a run of `size` beats, with an ap_start/ap_done control handshake.
module axis_data_chk
  import axis_data_chk_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter logic [15:0] BP_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      size,
  input  logic             bp_en,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [31:0]      err_count,
  output logic             err_flag,
  output logic [31:0]      first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  chk_state_t  state;
  logic [31:0] size_q;
  logic [31:0] beat_idx;
  logic        bp_en_q;
  logic [15:0] lfsr;

  logic start_acc;
  logic beat_acc;
  logic is_final;
  logic beat_err;
  logic lfsr_ready;

  assign start_acc = (state == IDLE) && ap_start;
  assign beat_acc  = s_axis_tvalid && s_axis_tready;
  assign is_final  = (beat_idx == size_q - 32'd1);
  assign beat_err  = (s_axis_tdata != beat_idx[WIDTH-1:0]) || (s_axis_tlast != is_final);

  // A zero seed would lock the LFSR; treat that state as "always ready" so a
  // misconfigured seed cannot stall the stream forever.
  assign lfsr_ready    = lfsr[0] || (lfsr == 16'd0);
  assign s_axis_tready = (state == RUN) && (!bp_en_q || lfsr_ready);
  assign ap_idle       = (state == IDLE);

  bp_lfsr u_bp_lfsr (
    .clk     (clk),
    .reset   (reset),
    .seed    (BP_SEED),
    .load    (start_acc),
    .advance (state == RUN),
    .state   (lfsr)
  );

  // DONE entered from RUN already carries ap_done; entered directly from a
  // zero-size start it first spends the ap_ready cycle with ap_done low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ap_done        <= 1'b0;
      ap_ready       <= 1'b0;
      size_q         <= 32'd0;
      bp_en_q        <= 1'b0;
      beat_idx       <= 32'd0;
      err_count      <= 32'd0;
      err_flag       <= 1'b0;
      first_err_idx  <= 32'd0;
      first_err_data <= '0;
    end else begin
      ap_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            size_q         <= size;
            bp_en_q        <= bp_en;
            beat_idx       <= 32'd0;
            err_count      <= 32'd0;
            err_flag       <= 1'b0;
            first_err_idx  <= 32'd0;
            first_err_data <= '0;
            ap_ready       <= 1'b1;
            ap_done        <= 1'b0;
            state          <= (size == 32'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (beat_acc) begin
            beat_idx <= beat_idx + 32'd1;
            if (beat_err) begin
              if (err_count != ERR_SAT) begin
                err_count <= err_count + 32'd1;
              end
              if (!err_flag) begin
                err_flag       <= 1'b1;
                first_err_idx  <= beat_idx;
                first_err_data <= s_axis_tdata;
              end
            end
            if (is_final) begin
              state   <= DONE;
              ap_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ap_done) begin
            ap_done <= 1'b0;
            state   <= IDLE;
          end else begin
            ap_done <= 1'b1;
          end
        end
        default: begin
          ap_done <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_data_chk.sv
// Directed bench for axis_data_chk: drives pattern runs with injected faults
// and compares run results against a scoreboard of expected outcomes.
module tb_axis_data_chk;

  localparam int          WIDTH = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  typedef struct {
    logic [31:0] cnt;
    logic        flag;
    logic [31:0] idx;
    logic [7:0]  data;
  } result_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      size;
  logic             bp_en;
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic [WIDTH-1:0] s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic [31:0]      err_count;
  logic             err_flag;
  logic [31:0]      first_err_idx;
  logic [WIDTH-1:0] first_err_data;

  result_t exp_q[$];
  int      checks   = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  axis_data_chk #(.WIDTH(WIDTH), .BP_SEED(SEED)) dut (
    .clk            (clk),
    .reset          (reset),
    .size           (size),
    .bp_en          (bp_en),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .err_count      (err_count),
    .err_flag       (err_flag),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR: taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsrNext(input logic [15:0] m);
    logic fb;
    fb = m[0] ^ m[2] ^ m[3] ^ m[5];
    return {fb, m[15:1]};
  endfunction

  function automatic logic [7:0] beatData(input int k, input int bad_idx, input logic [7:0] bad_val);
    logic [7:0] v;
    v = k[7:0];
    if (k == bad_idx) v = bad_val;
    return v;
  endfunction

  function automatic logic beatLast(input int k, input int n, input bit drop_last, input int extra_last);
    return ((k == n - 1) && !drop_last) || (k == extra_last);
  endfunction

  task automatic compareResults(input string tag);
    result_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_err_count"}, err_count, e.cnt);
      checkOutput({tag, "_err_flag"}, {31'd0, err_flag}, {31'd0, e.flag});
      checkOutput({tag, "_first_idx"}, first_err_idx, e.idx);
      checkOutput({tag, "_first_data"}, {24'd0, first_err_data}, {24'd0, e.data});
    end
  endtask

  // Runs one transfer of n beats; abort_after >= 0 resets the DUT right after
  // that beat is accepted instead of finishing the run.
  task automatic applyStimulus(input string tag, input int n, input bit bp,
                               input int bad_idx, input logic [7:0] bad_val,
                               input bit drop_last, input int extra_last,
                               input int abort_after);
    result_t    r;
    logic [15:0] m;
    logic [7:0] d;
    logic       l;
    logic       rdy;
    int         i;
    int         cyc;
    int         limit;
    int         budget;
    r.cnt = 0; r.flag = 1'b0; r.idx = 0; r.data = 8'd0;
    for (int k = 0; k < n; k++) begin
      d = beatData(k, bad_idx, bad_val);
      l = beatLast(k, n, drop_last, extra_last);
      if ((d != k[7:0]) || (l != (k == n - 1))) begin
        if (!r.flag) begin
          r.flag = 1'b1; r.idx = k; r.data = d;
        end
        r.cnt++;
      end
    end
    if (abort_after < 0) exp_q.push_back(r);

    size = n; bp_en = bp; ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    checkOutput({tag, "_ap_ready"}, {31'd0, ap_ready}, 32'd1);
    checkOutput({tag, "_ap_idle_run"}, {31'd0, ap_idle}, 32'd0);

    m = SEED; i = 0; cyc = 0; budget = n * 8 + 20;
    limit = (abort_after >= 0) ? abort_after + 1 : n;
    while (i < limit && cyc < budget) begin
      s_axis_tdata  = beatData(i, bad_idx, bad_val);
      s_axis_tlast  = beatLast(i, n, drop_last, extra_last);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      rdy = s_axis_tready;
      checkOutput({tag, "_tready"}, {31'd0, rdy}, bp ? {31'd0, m[0]} : 32'd1);
      @(posedge clk); #1;
      m = lfsrNext(m);
      cyc++;
      if (rdy) i++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (i < limit) checkOutput({tag, "_timeout_beats"}, i, limit);

    if (abort_after >= 0) begin
      checkOutput({tag, "_flag_before_reset"}, {31'd0, err_flag}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput({tag, "_rst_idle"}, {31'd0, ap_idle}, 32'd1);
      checkOutput({tag, "_rst_tready"}, {31'd0, s_axis_tready}, 32'd0);
      checkOutput({tag, "_rst_err_count"}, err_count, 32'd0);
      checkOutput({tag, "_rst_err_flag"}, {31'd0, err_flag}, 32'd0);
      checkOutput({tag, "_rst_done"}, {31'd0, ap_done}, 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_rst_done2"}, {31'd0, ap_done}, 32'd0);
    end else begin
      checkOutput({tag, "_ap_done"}, {31'd0, ap_done}, 32'd1);
      checkOutput({tag, "_done_idle"}, {31'd0, ap_idle}, 32'd0);
      checkOutput({tag, "_done_tready"}, {31'd0, s_axis_tready}, 32'd0);
      if (ap_done) compareResults(tag);
      @(posedge clk); #1;
      checkOutput({tag, "_done_pulse"}, {31'd0, ap_done}, 32'd0);
      checkOutput({tag, "_back_idle"}, {31'd0, ap_idle}, 32'd1);
      checkOutput({tag, "_hold_count"}, err_count, r.cnt);
    end
  endtask

  initial begin
    result_t z;
    logic [31:0] held;
    reset = 1'b1; size = 32'd0; bp_en = 1'b0; ap_start = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_idle", {31'd0, ap_idle}, 32'd1);
    checkOutput("rst_done", {31'd0, ap_done}, 32'd0);
    checkOutput("rst_ready", {31'd0, ap_ready}, 32'd0);
    checkOutput("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    checkOutput("rst_err_count", err_count, 32'd0);
    checkOutput("rst_err_flag", {31'd0, err_flag}, 32'd0);
    checkOutput("rst_first_idx", first_err_idx, 32'd0);
    checkOutput("rst_first_data", {24'd0, first_err_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] clean run, size=16, no backpressure");
    applyStimulus("clean16", 16, 1'b0, -1, 8'h00, 1'b0, -1, -1);

    $display("[TB] wrapping run, size=300, backpressure on");
    applyStimulus("wrap300", 300, 1'b1, -1, 8'h00, 1'b0, -1, -1);

    $display("[TB] bad data on beat 3 and missing tlast");
    applyStimulus("bad3", 8, 1'b0, 3, 8'h55, 1'b1, -1, -1);

    $display("[TB] early tlast on beat 4");
    applyStimulus("early4", 8, 1'b1, -1, 8'h00, 1'b0, 4, -1);

    $display("[TB] tvalid while idle is ignored");
    held = err_count;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("idle_valid_idle", {31'd0, ap_idle}, 32'd1);
      checkOutput("idle_valid_tready", {31'd0, s_axis_tready}, 32'd0);
    end
    checkOutput("idle_valid_count", err_count, held);
    s_axis_tvalid = 1'b0;

    $display("[TB] size=0 with ap_start held high");
    z.cnt = 0; z.flag = 1'b0; z.idx = 0; z.data = 8'd0;
    exp_q.push_back(z);
    exp_q.push_back(z);
    size = 32'd0; bp_en = 1'b0; ap_start = 1'b1;
    @(posedge clk); #1;
    checkOutput("zero_ready", {31'd0, ap_ready}, 32'd1);
    checkOutput("zero_done_low", {31'd0, ap_done}, 32'd0);
    checkOutput("zero_idle_low", {31'd0, ap_idle}, 32'd0);
    checkOutput("zero_tready_a", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("zero_done", {31'd0, ap_done}, 32'd1);
    checkOutput("zero_ready_low", {31'd0, ap_ready}, 32'd0);
    checkOutput("zero_tready_b", {31'd0, s_axis_tready}, 32'd0);
    if (ap_done) compareResults("zero_first");
    @(posedge clk); #1;
    checkOutput("zero_idle", {31'd0, ap_idle}, 32'd1);
    checkOutput("zero_done_off", {31'd0, ap_done}, 32'd0);
    @(posedge clk); #1;
    checkOutput("zero_reaccept", {31'd0, ap_ready}, 32'd1);
    ap_start = 1'b0;
    @(posedge clk); #1;
    checkOutput("zero_done2", {31'd0, ap_done}, 32'd1);
    if (ap_done) compareResults("zero_second");
    @(posedge clk); #1;
    checkOutput("zero_idle2", {31'd0, ap_idle}, 32'd1);

    $display("[TB] reset after beat 5 of size=10");
    applyStimulus("abort", 10, 1'b0, 2, 8'hAA, 1'b0, -1, 5);

    checkOutput("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_data_chk.md
Name: axis_data_chk

Overview:
- AXI-Stream sink and checker: the receive-side counterpart of the stream data generator.
- Each run consumes exactly `size` beats and compares every beat against the generator's incrementing pattern (beat i carries i[WIDTH-1:0]). It also checks that tlast appears on the final beat only.
- Uses the same ap_start/ap_done/ap_idle/ap_ready control handshake as the generator, so a bench can loop generator to checker.
- Optional pseudo-random backpressure on tready exercises the transmitter's stall handling.

Parameters:
- WIDTH, 8, tdata width in bits; legal range 1..32.
- BP_SEED, 16'hACE1, nonzero reset/start seed of the backpressure LFSR.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- size  input  32  beats per run; sampled when a start is accepted.
- bp_en  input  1  1 = throttle tready with the LFSR; 0 = tready high for the whole run. Sampled when a start is accepted.
- ap_start  input  1  run request; level, honoured only in IDLE.
- ap_done  output  1  one-cycle pulse at run end.
- ap_idle  output  1  high only in IDLE.
- ap_ready  output  1  one-cycle pulse when a start is accepted.
- s_axis_tdata  input  WIDTH  stream data.
- s_axis_tvalid  input  1  stream valid.
- s_axis_tlast  input  1  stream last.
- s_axis_tready  output  1  stream ready.
- err_count  output  32  error count for the last or current run; saturates at 32'hFFFFFFFF.
- err_flag  output  1  at least one error seen this run.
- first_err_idx  output  32  beat index of the first error; 0 when err_flag=0.
- first_err_data  output  WIDTH  tdata received at the first error; 0 when err_flag=0.

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: ap_done=0, ap_ready=0, ap_idle=1, tready=0, err_count=0, err_flag=0, first_err_idx=0, first_err_data=0, beat counter=0, LFSR=BP_SEED.
- Reset asserted mid-run aborts the run: no ap_done, results cleared, tready=0 in the cycle after the reset edge.
- Start accepted (IDLE and ap_start at a clock edge), on that edge:
  - latch size and bp_en;
  - clear the beat counter, err_count, err_flag, first_err_idx and first_err_data;
  - load the LFSR with BP_SEED;
  - ap_ready=1 for exactly the next cycle;
  - go to RUN, or to DONE if size==0.
- tready: combinational, = (state==RUN) && (!bp_en_q || lfsr[0]). It is never high outside RUN.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle while in RUN, independent of handshakes.
- Beat accepted when tvalid && tready. For beat index i:
  - data error when tdata != i[WIDTH-1:0]; the expected value wraps modulo 2^WIDTH;
  - last error when tlast != (i == size_q-1);
  - one beat carrying both errors counts once;
  - on the first error, capture first_err_idx=i and first_err_data=tdata, and set err_flag;
  - increment the counter after each accepted beat.
- The beat count, not tlast, ends the run: an early tlast is counted as an error and reception continues.
- On the accepted beat with i==size_q-1, go to DONE on that edge.
- DONE lasts exactly one cycle with ap_done=1 and ap_idle=0, then IDLE. ap_start high during DONE is ignored until IDLE.
- Back-to-back runs: ap_start held high gives the sequence ap_done, then IDLE (1 cycle), then accept.
- Result outputs hold their values from the end of a run until the next start is accepted.
- Latency: ap_done rises 1 cycle after the final beat handshake. With size==0, ap_done rises 2 cycles after the accepting edge (ap_ready cycle, then DONE).
- tvalid while not in RUN is ignored; no state change.

Decomposition:
- Package axis_data_chk_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the LFSR tap mask constant;
  - the ERR_SAT constant (all ones, 32 bits).
- Sub-module bp_lfsr (16-bit Fibonacci LFSR): inputs seed, load, advance; output the state vector. It is reusable by a future stream generator stall feature.

Test Plan:
- size=16, bp_en=0, ideal source 0..15 with tlast on beat 15 -> tready continuous 16 cycles, ap_done 1 cycle after beat 15, err_count=0, err_flag=0.
- size=300, WIDTH=8, bp_en=1, source honouring tready -> data wraps 255 to 0 with no error, tready duty matches the seeded LFSR sequence, err_count=0.
- size=8, beat 3 carries 8'h55 and tlast is missing on beat 7 -> err_count=2, first_err_idx=3, first_err_data=8'h55.
- size=8, tlast on beat 4 -> err_count=1, first_err_idx=4, all 8 beats consumed, ap_done after beat 7.
- size=0 with ap_start held high -> ap_ready, ap_done, ap_idle for 1 cycle, then a new ap_ready; tready never asserted.
- reset asserted after beat 5 of size=10 -> next cycle: ap_idle=1, tready=0, err_count=0, no ap_done.
